// File: rtl/tdc_readout_pkg.sv
// Shared definitions for the TDC frame readout: frame geometry, byte positions and
// sequencer state encoding (also used by the byte-select splitter).
package tdc_readout_pkg;

  localparam int NUM_BYTES      = 24;
  localparam int IDX_W          = $clog2(NUM_BYTES);
  localparam int SETTLE_W       = 4;
  localparam int SETTLE_CYC_DEF = 1;

  // Fixed frame layout
  localparam int FPGA_POS  = 0;
  localparam int VER_FIRST = 1;
  localparam int VER_LAST  = 5;
  localparam int PENC_POS  = 6;
  localparam int CNTR_FIRST = 7;
  localparam int CNTR_LAST  = 22;
  localparam int DAC_POS   = 23;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SEND   = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/readout_sequencer.sv
// Walks a one-hot byte select over the frame, samples each byte after SETTLE_CYC+1 cycles
// and offers it on tx_valid/tx_ready; back-pressure holds the current byte, abort drops to idle.
module readout_sequencer #(
  parameter int NUM_BYTES  = tdc_readout_pkg::NUM_BYTES,
  parameter int SETTLE_CYC = tdc_readout_pkg::SETTLE_CYC_DEF,
  parameter int IDX_W      = tdc_readout_pkg::IDX_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           byte_in,
  input  logic                 tx_ready,
  output logic [NUM_BYTES-1:0] sel_out,
  output logic [IDX_W-1:0]     sel_index,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 busy,
  output logic                 frame_done
);
  import tdc_readout_pkg::*;

  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYC);

  seq_state_t          state;
  logic [SETTLE_W-1:0] settle_cnt;

  always_ff @(posedge clk) begin
    // Abort has priority over everything but reset, so a start in the same cycle is dropped
    // and a coinciding last transfer never produces frame_done.
    if (!reset_n || abort) begin
      state      <= ST_IDLE;
      sel_out    <= '0;
      sel_index  <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      settle_cnt <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_out    <= NUM_BYTES'(1);
            sel_index  <= '0;
            settle_cnt <= SETTLE_INIT;
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end else begin
            tx_data  <= byte_in;
            tx_valid <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (sel_out[NUM_BYTES-1]) begin
              sel_out    <= '0;
              sel_index  <= '0;
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              sel_out    <= sel_out << 1;
              sel_index  <= sel_index + IDX_W'(1);
              settle_cnt <= SETTLE_INIT;
              state      <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench: one sequencer with SETTLE_CYC=1 and one with SETTLE_CYC=0, a byte-mux model
// returning 0xA0+position, and immediate-assertion checks at each step.
module tb_readout_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n;
  logic        start, abort, tx_ready;
  logic [7:0]  byte_in0, byte_in1;
  logic [23:0] sel0, sel1;
  logic [4:0]  idx0, idx1;
  logic [7:0]  data0, data1;
  logic        valid0, valid1, busy0, busy1, fd0, fd1;

  int checks = 0;
  int errors = 0;

  readout_sequencer #(.NUM_BYTES(24), .SETTLE_CYC(1), .IDX_W(5)) u_dut_n1 (
    .clk(clk), .reset_n(rst0_n), .start(start), .abort(abort), .byte_in(byte_in0),
    .tx_ready(tx_ready), .sel_out(sel0), .sel_index(idx0), .tx_data(data0),
    .tx_valid(valid0), .busy(busy0), .frame_done(fd0)
  );

  readout_sequencer #(.NUM_BYTES(24), .SETTLE_CYC(0), .IDX_W(5)) u_dut_n0 (
    .clk(clk), .reset_n(rst1_n), .start(start), .abort(abort), .byte_in(byte_in1),
    .tx_ready(tx_ready), .sel_out(sel1), .sel_index(idx1), .tx_data(data1),
    .tx_valid(valid1), .busy(busy1), .frame_done(fd1)
  );

  // Byte mux model: position of the selected bit, offset by 0xA0
  function automatic logic [7:0] mux_byte(input logic [23:0] s);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 24; i++) if (s[i]) p = 8'(i);
    return 8'hA0 + p;
  endfunction

  always_comb byte_in0 = mux_byte(sel0);
  always_comb byte_in1 = mux_byte(sel1);

  logic        dsel;
  logic [23:0] o_sel;
  logic [4:0]  o_idx;
  logic [7:0]  o_data;
  logic        o_valid, o_busy, o_fd;
  always_comb begin
    o_sel   = dsel ? sel1   : sel0;
    o_idx   = dsel ? idx1   : idx0;
    o_data  = dsel ? data1  : data0;
    o_valid = dsel ? valid1 : valid0;
    o_busy  = dsel ? busy1  : busy0;
    o_fd    = dsel ? fd1    : fd0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"},   32'(o_sel),   32'h0);
    chk({tag, "_idx"},   32'(o_idx),   32'h0);
    chk({tag, "_data"},  32'(o_data),  32'h0);
    chk({tag, "_valid"}, 32'(o_valid), 32'h0);
    chk({tag, "_busy"},  32'(o_busy),  32'h0);
    chk({tag, "_fd"},    32'(o_fd),    32'h0);
  endtask

  // Starts a frame and follows it; cycle 1 is the first negedge after the start edge.
  task automatic run_frame(input string tag, input int n, input int stall_k, input int stall_len,
                           input int repulse_cyc, input int abort_k);
    int cyc, k, done_cyc, done_cnt, first_v, stall_left, fd_late;
    bit aborted;
    k = 0; done_cyc = -1; done_cnt = 0; first_v = -1; stall_left = stall_len; aborted = 0;
    start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_first_sel"}, 32'(o_sel), 32'h1);
    chk({tag, "_busy"}, 32'(o_busy), 32'h1);
    while (cyc < 400) begin
      if (o_fd) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_valid && first_v < 0) first_v = cyc;
      start = (cyc == repulse_cyc);
      tx_ready = 1'b1;
      if (o_valid && k < 24) begin
        if (k == abort_k) begin
          abort = 1'b1;
          aborted = 1;
        end else if (k == stall_k && stall_left > 0) begin
          tx_ready = 1'b0;
          stall_left--;
          chk({tag, "_hold_data"}, 32'(o_data), 32'(8'hA0 + 8'(k)));
          chk({tag, "_hold_sel"}, 32'(o_sel), 32'(24'(1) << k));
        end else begin
          chk({tag, "_data"}, 32'(o_data), 32'(8'hA0 + 8'(k)));
          chk({tag, "_sel"}, 32'(o_sel), 32'(24'(1) << k));
          chk({tag, "_idx"}, 32'(o_idx), 32'(k));
          k++;
        end
      end
      @(negedge clk);
      cyc++;
      if (aborted) break;
      if (done_cnt > 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
    if (aborted) begin
      abort = 1'b0;
      chk_idle({tag, "_abort"});
      fd_late = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (o_fd) fd_late++;
      end
      chk({tag, "_abort_no_fd"}, 32'(fd_late), 32'h0);
      chk({tag, "_abort_busy"}, 32'(o_busy), 32'h0);
    end else begin
      chk({tag, "_bytes"}, 32'(k), 32'd24);
      chk({tag, "_fd_count"}, 32'(done_cnt), 32'd1);
      chk({tag, "_fd_cycle"}, 32'(done_cyc), 32'(1 + 24 * (n + 2) + stall_len));
      chk({tag, "_first_valid"}, 32'(first_v), 32'(2 + n));
      chk({tag, "_end_busy"}, 32'(o_busy), 32'h0);
      chk({tag, "_end_sel"}, 32'(o_sel), 32'h0);
      chk({tag, "_end_valid"}, 32'(o_valid), 32'h0);
    end
  endtask

  initial begin
    dsel = 1'b0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    start = 1'b1; abort = 1'b0; tx_ready = 1'b1;

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst0_n = 1'b1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk_idle("post_reset");

    // Start and abort together in idle: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", 32'(o_busy), 32'h0);
    chk("start_abort_sel", 32'(o_sel), 32'h0);

    run_frame("full_n1", 1, -1, 0, -1, -1);
    run_frame("stall", 1, 7, 5, -1, -1);
    run_frame("abort12", 1, -1, 0, -1, 12);
    run_frame("after_abort", 1, -1, 0, -1, -1);
    run_frame("repulse_mid", 1, -1, 0, 20, -1);
    run_frame("repulse_done", 1, -1, 0, 73, -1);

    // SETTLE_CYC=0 instance
    rst0_n = 1'b0;
    rst1_n = 1'b1;
    dsel = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("n0_idle");
    run_frame("full_n0", 0, -1, 0, -1, -1);

    // Mid-frame synchronous reset
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("n0_mid_busy", 32'(o_busy), 32'h1);
    rst1_n = 1'b0;
    @(negedge clk);
    chk_idle("n0_mid_reset");
    rst1_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("n0_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
